mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_rr2_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Holds the FSM state encoding, the grant encoding and default parameter values.
// No logic here; imported by mem_arbiter and rr2_pick.
package mem_arb_pkg;

  localparam int DEF_WAIT = 2;
  localparam int DEF_AW   = 16;
  localparam int DEF_DW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_I_ACC = 2'd1,
    ST_D_ACC = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_rr2_pick.sv
// Two-way round-robin selector between the fetch and data requesters.
// Purely combinational, zero latency.
// No backpressure of its own; the caller only samples it while idle.
module rr2_pick
  import mem_arb_pkg::*;
(
  input  logic   eligible_i,
  input  logic   eligible_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant_sel
);

  // A lone requester wins; on a tie the side that did not win last time goes.
  always_comb begin
    grant_valid = eligible_i | eligible_d;
    grant_sel   = GNT_D;
    if (eligible_i && eligible_d) begin
      grant_sel = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (eligible_i) begin
      grant_sel = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Grant edge -> m_en for WAIT cycles -> one-cycle ready pulse on the following cycle.
// Requesters hold req until ready; stall_f/stall_m expose the wait to the pipeline.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = DEF_WAIT,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  // Counter value seen in the final memory cycle of an access.
  localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

  state_t     state;
  grant_t     last_grant;
  logic [3:0] cnt;
  logic       eligible_i;
  logic       eligible_d;
  logic       grant_valid;
  grant_t     grant_sel;

  // A ready pulse blocks its own requester for that cycle, so a held
  // request is not re-served from stale inputs.
  assign eligible_i = i_req & ~i_ready;
  assign eligible_d = d_req & ~d_ready;
  assign stall_f    = i_req & ~i_ready;
  assign stall_m    = d_req & ~d_ready;

  rr2_pick u_pick (
    .eligible_i  (eligible_i),
    .eligible_d  (eligible_d),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // Arbitration FSM: latches the winner onto m_*, counts WAIT cycles, returns data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GNT_D;
      cnt        <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_sel;
            cnt        <= '0;
            m_en       <= 1'b1;
            if (grant_sel == GNT_I) begin
              state  <= ST_I_ACC;
              m_addr <= i_addr;
              m_we   <= 1'b0;
            end else begin
              state   <= ST_D_ACC;
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end
          end
        end
        ST_I_ACC, ST_D_ACC: begin
          // Top value is WAIT (<= 15), so the 4-bit counter cannot wrap.
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= ST_IDLE;
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            if (state == ST_I_ACC) begin
              i_rdata <= m_rdata;
              i_ready <= 1'b1;
            end else begin
              // m_we still reflects the latched direction in the last cycle.
              if (!m_we) d_rdata <= m_rdata;
              d_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The counter is 4 bits wide, so only 1..15 memory cycles are representable.
  wait_in_range: assert property (@(posedge clk) (WAIT >= 1) && (WAIT <= 15));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction schedule model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_en, m_we, stall_f, stall_m;

  logic        i1_req;
  logic [15:0] i1_addr, m1_rdata;
  logic [15:0] i1_rdata, d1_rdata, m1_addr, m1_wdata;
  logic        i1_ready, d1_ready, m1_en, m1_we, stall1_f, stall1_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT(2), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_arbiter #(.WAIT(1), .AW(16), .DW(16)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_ready(i1_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_rdata(d1_rdata), .d_ready(d1_ready),
    .m_en(m1_en), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_rdata(m1_rdata),
    .stall_f(stall1_f), .stall_m(stall1_m)
  );

  typedef struct {
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq, dwe;
    logic [15:0] daddr, dwdata, mrdata;
    logic        en, we;
    logic [15:0] maddr;
    logic        irdy, drdy;
    logic [15:0] irdata, drdata;
    logic        sf, sm;
  } vec_t;

  function automatic vec_t mk(logic ireq, logic [15:0] iaddr, logic dreq, logic dwe,
                              logic [15:0] daddr, logic [15:0] dwdata, logic [15:0] mrdata,
                              logic en, logic we, logic [15:0] maddr, logic irdy, logic drdy,
                              logic [15:0] irdata, logic [15:0] drdata, logic sf, logic sm);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.mrdata = mrdata;
    v.en = en; v.we = we; v.maddr = maddr; v.irdy = irdy; v.drdy = drdy;
    v.irdata = irdata; v.drdata = drdata; v.sf = sf; v.sm = sm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; i1_req = 1'b0; i1_addr = '0; m1_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Records the address of every access start; requesters drop req after ready.
  logic [15:0] gq[$];
  task automatic run_grants(input int n);
    logic pen, ir, dr;
    gq.delete();
    pen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (m_en && !pen) gq.push_back(m_addr);
      pen = m_en; ir = i_ready; dr = d_ready;
      @(posedge clk); #1;
      if (ir) i_req = 1'b0;
      if (dr) d_req = 1'b0;
    end
  endtask

  function automatic logic [15:0] grant_at(int idx);
    if (gq.size() > idx) return gq[idx];
    return 16'hxxxx;
  endfunction

  vec_t tbl[13];

  // Schedule model state (cycle numbers of the current access and ready pulses).
  int          a_start, a_end, irc, drc;
  logic        owner_d, last_d, e_we, e_en, ei, ed, pick_d, ir, dr;
  logic [15:0] e_addr, e_wdata, e_ird, e_drd;

  initial begin
    do_reset();

    // Directed table: lone fetch, write, then read with address change mid-access.
    tbl[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[1]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h1111, 1, 0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[2]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, 1, 0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0);
    tbl[3]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0010, 1, 0, 16'hA5A5, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 16'h0010, 1, 1, 16'h0030, 16'h1234, 16'h0000, 0, 0, 16'h0010, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[5]  = mk(0, 16'h0010, 1, 1, 16'h0030, 16'h1234, 16'hDEAD, 1, 1, 16'h0030, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[6]  = mk(0, 16'h0010, 1, 1, 16'h0030, 16'h1234, 16'hBEEF, 1, 1, 16'h0030, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[7]  = mk(0, 16'h0010, 1, 1, 16'h0030, 16'h1234, 16'h0000, 0, 0, 16'h0030, 0, 1, 16'hA5A5, 16'h0000, 0, 0);
    tbl[8]  = mk(0, 16'h0010, 1, 0, 16'h0040, 16'h1234, 16'h0000, 0, 0, 16'h0030, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[9]  = mk(0, 16'h0010, 1, 0, 16'h0050, 16'h1234, 16'h2222, 1, 0, 16'h0040, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[10] = mk(0, 16'h0010, 1, 0, 16'h0050, 16'h1234, 16'h4040, 1, 0, 16'h0040, 0, 0, 16'hA5A5, 16'h0000, 0, 1);
    tbl[11] = mk(0, 16'h0010, 1, 0, 16'h0050, 16'h1234, 16'h0000, 0, 0, 16'h0040, 0, 1, 16'hA5A5, 16'h4040, 0, 0);
    tbl[12] = mk(0, 16'h0010, 0, 0, 16'h0050, 16'h1234, 16'h0000, 0, 0, 16'h0040, 0, 0, 16'hA5A5, 16'h4040, 0, 0);

    for (int r = 0; r < 13; r++) begin
      i_req = tbl[r].ireq; i_addr = tbl[r].iaddr; d_req = tbl[r].dreq; d_we = tbl[r].dwe;
      d_addr = tbl[r].daddr; d_wdata = tbl[r].dwdata; m_rdata = tbl[r].mrdata;
      @(negedge clk);
      chk($sformatf("vec%0d", r),
          {m_en, m_we, m_addr, i_ready, d_ready, i_rdata, d_rdata, stall_f, stall_m},
          {tbl[r].en, tbl[r].we, tbl[r].maddr, tbl[r].irdy, tbl[r].drdy,
           tbl[r].irdata, tbl[r].drdata, tbl[r].sf, tbl[r].sm});
      @(posedge clk); #1;
    end

    // Tie after reset goes to fetch; after a lone fetch the next tie goes to data.
    do_reset();
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0020; m_rdata = 16'h7777;
    run_grants(14);
    chk("tie1_count", gq.size(), 2);
    chk("tie1_first", grant_at(0), 16'h0100);
    chk("tie1_second", grant_at(1), 16'h0020);
    chk("tie1_d_rdata", d_rdata, 16'h7777);
    i_req = 1; i_addr = 16'h0200;
    run_grants(6);
    chk("lone_fetch", grant_at(0), 16'h0200);
    i_req = 1; i_addr = 16'h0300; d_req = 1; d_addr = 16'h0060;
    run_grants(14);
    chk("tie2_first", grant_at(0), 16'h0060);
    chk("tie2_second", grant_at(1), 16'h0300);

    // Reset asserted in the second fetch cycle aborts the access.
    do_reset();
    i_req = 1; i_addr = 16'h0010; m_rdata = 16'h3333;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_first_acc_en", m_en, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_second_acc_en", m_en, 1);
    chk("rst_stall_f_held", stall_f, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_abort_outputs", {m_en, m_we, i_ready, d_ready, m_addr, m_wdata, i_rdata, d_rdata},
        {4'b0000, 64'h0});
    chk("rst_stall_f_in_reset", stall_f, 1);
    @(posedge clk); #1;
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("rst_no_ready_after", {i_ready, m_en}, 2'b00);
    @(posedge clk); #1;

    // WAIT=1 instance with a permanently held fetch request.
    do_reset();
    i1_req = 1; i1_addr = 16'h0ABC; m1_rdata = 16'h5A5A;
    begin
      int last_r, consec, nrdy;
      logic pen1;
      last_r = -1; consec = 0; nrdy = 0; pen1 = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (m1_en && pen1) consec++;
        pen1 = m1_en;
        if (i1_ready) begin
          if (last_r >= 0) chk("w1_spacing", c - last_r, 3);
          else chk("w1_first_ready", c, 2);
          last_r = c;
          nrdy++;
        end
        @(posedge clk); #1;
      end
      chk("w1_no_back_to_back_en", consec, 0);
      chk("w1_ready_count", nrdy, 10);
      chk("w1_rdata", i1_rdata, 16'h5A5A);
    end
    i1_req = 0;

    // Randomized run against the schedule model.
    do_reset();
    a_start = 0; a_end = -1; irc = -5; drc = -5;
    owner_d = 0; last_d = 1; e_we = 0;
    e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
    i_req = 1'($urandom_range(0, 1)); i_addr = 16'($urandom);
    d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
    d_addr = 16'($urandom); d_wdata = 16'($urandom); m_rdata = 16'($urandom);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      e_en = (c >= a_start) && (c <= a_end);
      chk("rnd_m_en", m_en, e_en);
      chk("rnd_m_we", m_we, e_en && e_we);
      chk("rnd_m_addr", m_addr, e_addr);
      if (e_en && e_we) chk("rnd_m_wdata", m_wdata, e_wdata);
      chk("rnd_i_ready", i_ready, c == irc);
      chk("rnd_d_ready", d_ready, c == drc);
      chk("rnd_i_rdata", i_rdata, e_ird);
      chk("rnd_d_rdata", d_rdata, e_drd);
      chk("rnd_stall_f", stall_f, i_req && (c != irc));
      chk("rnd_stall_m", stall_m, d_req && (c != drc));
      // Completion in the last memory cycle of an access.
      if (c == a_end) begin
        if (!owner_d) begin
          e_ird = m_rdata; irc = c + 1;
        end else begin
          if (!e_we) e_drd = m_rdata;
          drc = c + 1;
        end
      end
      // New grant when the memory is free.
      ei = i_req && (c != irc);
      ed = d_req && (c != drc);
      if ((c > a_end) && (ei || ed)) begin
        pick_d = (ei && ed) ? !last_d : ed;
        owner_d = pick_d; last_d = pick_d;
        a_start = c + 1; a_end = c + 2;
        if (pick_d) begin
          e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
        end else begin
          e_addr = i_addr; e_we = 1'b0;
        end
      end
      ir = i_ready; dr = d_ready;
      @(posedge clk); #1;
      if (!i_req || ir) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = 16'($urandom);
      end
      if (!d_req || dr) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      m_rdata = 16'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
